fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the word-fetch address into the combinational-read instruction memory. It captures the returned instruction into the IF/ID pipeline register for decode. It handles pipeline stall, branch/jump redirect with wrong-path squash, and fetch-fault detection with a sticky halt.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_if_id_reg.sv | 54 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_unit_pkg;

    localparam int                 FETCH_CPU_WIDTH     = 32;
    localparam logic [31:0]        FETCH_RESET_PC      = 32'h0000_0000;
    localparam int                 INST_MEM_ADDR_DEPTH = 1024;
    localparam int                 INST_MEM_BYTES      = 4 * INST_MEM_ADDR_DEPTH;
    localparam logic [31:0]        INST_NOP            = 32'h0000_0013;

    typedef enum logic {
        FETCH_ST_RUN  = 1'b0,
        FETCH_ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with hold and squash
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int                   WIDTH    = FETCH_CPU_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             squash_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] inst_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] inst_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic             valid_q, valid_d;

    // Squash beats hold; the pc field is left alone so decode still sees the last real PC.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (squash_i) begin
            inst_d  = WIDTH'(INST_NOP);
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= WIDTH'(INST_NOP);
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, redirect/squash, fetch-fault detection and sticky halt
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   CPU_WIDTH           = FETCH_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC_VALUE      = CPU_WIDTH'(FETCH_RESET_PC),
    parameter int                   INST_MEM_ADDR_DEPTH = fetch_unit_pkg::INST_MEM_ADDR_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 redirect_valid_i,
    input  logic [CPU_WIDTH-1:0] redirect_pc_i,
    output logic [CPU_WIDTH-1:0] pc_addr_o,
    input  logic [CPU_WIDTH-1:0] inst_i,
    output logic [CPU_WIDTH-1:0] if_id_pc_o,
    output logic [CPU_WIDTH-1:0] if_id_inst_o,
    output logic                 if_id_valid_o,
    output logic                 fetch_fault_o,
    output logic [CPU_WIDTH-1:0] fault_pc_o,
    output logic [31:0]          fetch_cnt_o
);

    localparam logic [CPU_WIDTH-1:0] MEM_BYTES = CPU_WIDTH'(4 * INST_MEM_ADDR_DEPTH);

    fetch_state_e         state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic                 fault_q, fault_d;
    logic [CPU_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 fault_cond;
    logic                 if_id_hold;
    logic                 if_id_squash;

    // Unsigned offset compare also catches PCs below the window and a +4 wrap past 2^W.
    assign fault_cond = (pc_q[1:0] != 2'b00) || ((pc_q - RESET_PC_VALUE) >= MEM_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == FETCH_ST_RUN && !redirect_valid_i && fault_cond) begin
            state_d = FETCH_ST_HALT;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        cnt_d        = cnt_q;
        if_id_hold   = 1'b1;
        if_id_squash = 1'b0;
        case (state_q)
            FETCH_ST_RUN: begin
                if (redirect_valid_i) begin
                    pc_d         = redirect_pc_i;
                    if_id_squash = 1'b1;
                end else if (fault_cond) begin
                    fault_d      = 1'b1;
                    fault_pc_d   = pc_q;
                    if_id_squash = 1'b1;
                end else if (!stall_i) begin
                    pc_d       = pc_q + CPU_WIDTH'(4);
                    cnt_d      = cnt_q + 32'd1;
                    if_id_hold = 1'b0;
                end
            end
            default: begin
                if_id_squash = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC_VALUE;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    if_id_reg #(
        .WIDTH    (CPU_WIDTH),
        .RESET_PC (RESET_PC_VALUE)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (if_id_hold),
        .squash_i (if_id_squash),
        .pc_i     (pc_q),
        .inst_i   (inst_i),
        .pc_o     (if_id_pc_o),
        .inst_o   (if_id_inst_o),
        .valid_o  (if_id_valid_o)
    );

    assign pc_addr_o     = pc_q;
    assign fetch_fault_o = fault_q;
    assign fault_pc_o    = fault_pc_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_addr_o;
    logic [31:0] inst_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fault_pc_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: word k holds 0x100 + k.
    assign inst_i = 32'h100 + (pc_addr_o >> 2);

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_addr_o        (pc_addr_o),
        .inst_i           (inst_i),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_inst_o     (if_id_inst_o),
        .if_id_valid_o    (if_id_valid_o),
        .fetch_fault_o    (fetch_fault_o),
        .fault_pc_o       (fault_pc_o),
        .fetch_cnt_o      (fetch_cnt_o)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc_addr;
        logic [31:0] if_pc;
        logic [31:0] if_inst;
        logic        if_valid;
        logic        fault;
        logic [31:0] fault_pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        rst              = r;
        stall_i          = s;
        redirect_valid_i = rv;
        redirect_pc_i    = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pa, input logic [31:0] ipc,
                           input logic [31:0] iinst, input logic iv, input logic f,
                           input logic [31:0] fpc, input logic [31:0] cnt);
        chk({tag, ".pc_addr"}, pc_addr_o, pa);
        chk({tag, ".if_pc"}, if_id_pc_o, ipc);
        chk({tag, ".if_inst"}, if_id_inst_o, iinst);
        chk({tag, ".if_valid"}, 32'(if_id_valid_o), 32'(iv));
        chk({tag, ".fault"}, 32'(fetch_fault_o), 32'(f));
        chk({tag, ".fault_pc"}, fault_pc_o, fpc);
        chk({tag, ".cnt"}, fetch_cnt_o, cnt);
    endtask

    task automatic chk_reset(input string tag);
        chk_all(tag, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        //         stall redir rpc       pc_addr   if_pc     if_inst   v     fault fpc    cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h4,    32'h0,    32'h100,  1'b1, 1'b0, 32'h0,  32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h8,    32'h4,    32'h101,  1'b1, 1'b0, 32'h0,  32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h8,    32'h4,    32'h101,  1'b1, 1'b0, 32'h0,  32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h8,    32'h4,    32'h101,  1'b1, 1'b0, 32'h0,  32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,  32'h8,    32'h4,    32'h101,  1'b1, 1'b0, 32'h0,  32'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'hC,    32'h8,    32'h102,  1'b1, 1'b0, 32'h0,  32'd3};
        vecs[6]  = '{1'b1, 1'b1, 32'h40, 32'h40,   32'h8,    NOP,      1'b0, 1'b0, 32'h0,  32'd3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h44,   32'h40,   32'h110,  1'b1, 1'b0, 32'h0,  32'd4};
        vecs[8]  = '{1'b0, 1'b1, 32'h42, 32'h42,   32'h40,   NOP,      1'b0, 1'b0, 32'h0,  32'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  32'h42,   32'h40,   NOP,      1'b0, 1'b1, 32'h42, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 32'h80, 32'h42,   32'h40,   NOP,      1'b0, 1'b1, 32'h42, 32'd4};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  32'h42,   32'h40,   NOP,      1'b0, 1'b1, 32'h42, 32'd4};

        rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_reset("reset0");

        for (int i = 0; i < 12; i++) begin
            step(1'b0, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            chk_all($sformatf("vec%0d", i), vecs[i].pc_addr, vecs[i].if_pc, vecs[i].if_inst,
                    vecs[i].if_valid, vecs[i].fault, vecs[i].fault_pc, vecs[i].cnt);
        end

        // Reset out of HALT clears everything.
        step(1'b1, 1'b1, 1'b1, 32'h80);
        chk_reset("reset_halt");

        // Sequential run across the top of the window.
        step(1'b0, 1'b0, 1'b1, 32'hFF8);
        chk_all("top.redir", 32'hFF8, 32'h0, NOP, 1'b0, 1'b0, 32'h0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("top.ff8", 32'hFFC, 32'hFF8, 32'h4FE, 1'b1, 1'b0, 32'h0, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("top.ffc", 32'h1000, 32'hFFC, 32'h4FF, 1'b1, 1'b0, 32'h0, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_all("top.fault", 32'h1000, 32'hFFC, NOP, 1'b0, 1'b1, 32'h1000, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("top.frozen", 32'h1000, 32'hFFC, NOP, 1'b0, 1'b1, 32'h1000, 32'd2);

        // Redirect in the same cycle the PC is out of window suppresses the fault.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_reset("reset_mid");
        step(1'b0, 1'b0, 1'b1, 32'hFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("sup.ffc", 32'h1000, 32'hFFC, 32'h4FF, 1'b1, 1'b0, 32'h0, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h20);
        chk_all("sup.redir", 32'h20, 32'hFFC, NOP, 1'b0, 1'b0, 32'h0, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("sup.target", 32'h24, 32'h20, 32'h108, 1'b1, 1'b0, 32'h0, 32'd2);

        // Reset asserted during a stall/redirect.
        step(1'b1, 1'b1, 1'b1, 32'h40);
        chk_reset("reset_stall");
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("post_reset", 32'h4, 32'h0, 32'h100, 1'b1, 1'b0, 32'h0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
